instruction_sequencer: RTL and testbench

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/instruction_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_instruction_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control with HALT and TRAP stops.
// Latency: ALU/JAL/JALR 4 cycles, BRANCH/FENCE 3, LOAD 5, STORE 4, plus fetch and memory wait states.
// Backpressure: stalls in FETCH until inst_ready and in MEMORY until data_ready; no other stall points.
//
// Ports:
//   clock, reset                  sole clock; asynchronous active-high reset
//   inst_ready, inst_opcode       instruction fetch handshake and opcode field of the IR
//   data_ready                    data memory access completion
//   next_pc_select                next-PC choice from the control transfer unit
//   inst_read_enable .. pc_write_enable   datapath strobes
//   pc_select                     PC mux select, valid only with pc_write_enable
//   instret                       retired-instruction counter (wraps)
//   halted, trap                  sticky stop indications, cleared only by reset
module instruction_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        inst_ready,
    input  logic [6:0]  inst_opcode,
    input  logic        data_ready,
    input  logic [1:0]  next_pc_select,
    output logic        inst_read_enable,
    output logic        ir_write_enable,
    output logic        data_read_enable,
    output logic        data_write_enable,
    output logic        reg_write_enable,
    output logic        pc_write_enable,
    output logic [1:0]  pc_select,
    output logic [31:0] instret,
    output logic        halted,
    output logic        trap
);

    // Sequencer states
    localparam logic [2:0] ST_FETCH     = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_EXECUTE   = 3'd2;
    localparam logic [2:0] ST_MEMORY    = 3'd3;
    localparam logic [2:0] ST_WRITEBACK = 3'd4;
    localparam logic [2:0] ST_HALT      = 3'd5;
    localparam logic [2:0] ST_TRAP      = 3'd6;

    // Instruction classes held across EXECUTE/MEMORY/WRITEBACK
    localparam logic [3:0] CL_NONE     = 4'd0;
    localparam logic [3:0] CL_LOAD     = 4'd1;
    localparam logic [3:0] CL_STORE    = 4'd2;
    localparam logic [3:0] CL_OP       = 4'd3;
    localparam logic [3:0] CL_OP_IMM   = 4'd4;
    localparam logic [3:0] CL_LUI      = 4'd5;
    localparam logic [3:0] CL_AUIPC    = 4'd6;
    localparam logic [3:0] CL_BRANCH   = 4'd7;
    localparam logic [3:0] CL_JAL      = 4'd8;
    localparam logic [3:0] CL_JALR     = 4'd9;
    localparam logic [3:0] CL_MISC_MEM = 4'd10;
    localparam logic [3:0] CL_SYSTEM   = 4'd11;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    function automatic logic [3:0] classify(input logic [6:0] opc);
        logic [3:0] cls;
        case (opc)
            OPC_LOAD:     cls = CL_LOAD;
            OPC_STORE:    cls = CL_STORE;
            OPC_OP:       cls = CL_OP;
            OPC_OP_IMM:   cls = CL_OP_IMM;
            OPC_LUI:      cls = CL_LUI;
            OPC_AUIPC:    cls = CL_AUIPC;
            OPC_BRANCH:   cls = CL_BRANCH;
            OPC_JAL:      cls = CL_JAL;
            OPC_JALR:     cls = CL_JALR;
            OPC_MISC_MEM: cls = CL_MISC_MEM;
            OPC_SYSTEM:   cls = CL_SYSTEM;
            default:      cls = CL_NONE;
        endcase
        return cls;
    endfunction

    logic [2:0] state;
    logic [2:0] state_next;
    logic [3:0] inst_class;
    logic [3:0] decoded_class;

    assign decoded_class = classify(inst_opcode);

    // Next-state logic. Only DECODE looks at the live opcode; later states
    // steer on the latched class so the IR may change underneath them.
    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: begin
                if (inst_ready) begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (decoded_class == CL_SYSTEM) begin
                    state_next = ST_HALT;
                end else if (decoded_class == CL_NONE) begin
                    state_next = ST_TRAP;
                end else begin
                    state_next = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                case (inst_class)
                    CL_LOAD, CL_STORE:                    state_next = ST_MEMORY;
                    CL_BRANCH, CL_MISC_MEM:               state_next = ST_FETCH;
                    CL_OP, CL_OP_IMM, CL_LUI, CL_AUIPC,
                    CL_JAL, CL_JALR:                      state_next = ST_WRITEBACK;
                    // Unreachable: DECODE never lets other classes through.
                    default:                              state_next = ST_TRAP;
                endcase
            end
            ST_MEMORY: begin
                if (data_ready) begin
                    state_next = (inst_class == CL_LOAD) ? ST_WRITEBACK : ST_FETCH;
                end
            end
            ST_WRITEBACK: state_next = ST_FETCH;
            ST_HALT:      state_next = ST_HALT;
            ST_TRAP:      state_next = ST_TRAP;
            // Illegal encoding: stop rather than run with corrupted control.
            default:      state_next = ST_TRAP;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inst_class <= CL_NONE;
        end else if (state == ST_DECODE) begin
            inst_class <= decoded_class;
        end
    end

    // Output decodes. ir_write_enable is gated by reset because the reset
    // state is FETCH and a concurrent inst_ready must not load the IR.
    assign inst_read_enable  = (state == ST_FETCH);
    assign ir_write_enable   = (state == ST_FETCH) && inst_ready && !reset;
    assign data_read_enable  = (state == ST_MEMORY) && (inst_class == CL_LOAD);
    assign data_write_enable = (state == ST_MEMORY) && (inst_class == CL_STORE);
    assign reg_write_enable  = (state == ST_WRITEBACK);
    assign halted            = (state == ST_HALT);
    assign trap              = (state == ST_TRAP);

    // Retirement points: BRANCH/FENCE in EXECUTE, STORE on its memory
    // completion, everything else in WRITEBACK. Exactly one per instruction.
    assign pc_write_enable = ((state == ST_EXECUTE) &&
                              ((inst_class == CL_BRANCH) || (inst_class == CL_MISC_MEM)))
                           || ((state == ST_MEMORY) && (inst_class == CL_STORE) && data_ready)
                           || (state == ST_WRITEBACK);

    assign pc_select = pc_write_enable ? next_pc_select : 2'b00;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instret <= 32'd0;
        end else if (pc_write_enable) begin
            instret <= instret + 32'd1;
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
module tb_instruction_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        inst_ready = 1'b0;
    logic [6:0]  inst_opcode = 7'd0;
    logic        data_ready = 1'b0;
    logic [1:0]  next_pc_select = 2'b00;
    logic        inst_read_enable;
    logic        ir_write_enable;
    logic        data_read_enable;
    logic        data_write_enable;
    logic        reg_write_enable;
    logic        pc_write_enable;
    logic [1:0]  pc_select;
    logic [31:0] instret;
    logic        halted;
    logic        trap;

    int checks = 0;
    int errors = 0;

    // Output vector order: {ire, irw, dre, dwe, rwe, pwe, halted, trap}
    localparam logic [7:0] O_IDLE  = 8'h00;
    localparam logic [7:0] O_FETCH = 8'h80;
    localparam logic [7:0] O_IRW   = 8'hC0;
    localparam logic [7:0] O_DRE   = 8'h20;
    localparam logic [7:0] O_DWE   = 8'h10;
    localparam logic [7:0] O_STEND = 8'h14;
    localparam logic [7:0] O_WB    = 8'h0C;
    localparam logic [7:0] O_PWE   = 8'h04;
    localparam logic [7:0] O_HLT   = 8'h02;
    localparam logic [7:0] O_TRP   = 8'h01;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_BAD    = 7'b1111111;

    instruction_sequencer dut (
        .clock             (clock),
        .reset             (reset),
        .inst_ready        (inst_ready),
        .inst_opcode       (inst_opcode),
        .data_ready        (data_ready),
        .next_pc_select    (next_pc_select),
        .inst_read_enable  (inst_read_enable),
        .ir_write_enable   (ir_write_enable),
        .data_read_enable  (data_read_enable),
        .data_write_enable (data_write_enable),
        .reg_write_enable  (reg_write_enable),
        .pc_write_enable   (pc_write_enable),
        .pc_select         (pc_select),
        .instret           (instret),
        .halted            (halted),
        .trap              (trap)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] outs();
        return {24'd0, inst_read_enable, ir_write_enable, data_read_enable, data_write_enable,
                reg_write_enable, pc_write_enable, halted, trap};
    endfunction

    // Check the current cycle's strobes and pc_select, then advance one clock.
    task automatic cyc(input string tag, input logic [7:0] exp_o, input logic [1:0] exp_sel);
        #1;
        check_val({tag, "_en"}, outs(), {24'd0, exp_o});
        check_val({tag, "_sel"}, {30'd0, pc_select}, {30'd0, exp_sel});
        @(posedge clock);
        #1;
    endtask

    // Fetch (with inst_ready) and decode of one opcode.
    task automatic fetch_decode(input string tag, input logic [6:0] opc, input logic [1:0] nps);
        inst_opcode    = opc;
        next_pc_select = nps;
        inst_ready     = 1'b1;
        cyc({tag, "_f"}, O_IRW, 2'b00);
        inst_ready     = 1'b0;
        cyc({tag, "_d"}, O_IDLE, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with inst_ready high: no IR load, no advance
        #1;
        reset      = 1'b1;
        inst_ready = 1'b1;
        #1;
        check_val("rst_en", outs(), {24'd0, O_FETCH});
        check_val("rst_instret", instret, 32'd0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        check_val("rst_hold_en", outs(), {24'd0, O_FETCH});
        reset = 1'b0;

        // ADD, inst_ready ignored after FETCH, opcode changed after DECODE
        inst_opcode    = OPC_OP;
        next_pc_select = 2'b00;
        cyc("add_f", O_IRW, 2'b00);
        cyc("add_d", O_IDLE, 2'b00);
        inst_opcode = OPC_LOAD;
        cyc("add_e", O_IDLE, 2'b00);
        inst_ready = 1'b0;
        cyc("add_wb", O_WB, 2'b00);
        check_val("add_instret", instret, 32'd1);

        // LOAD with data_ready held off 3 cycles; early data_ready ignored
        inst_opcode = OPC_LOAD;
        inst_ready  = 1'b1;
        data_ready  = 1'b1;
        cyc("ld_f", O_IRW, 2'b00);
        inst_ready = 1'b0;
        cyc("ld_d", O_IDLE, 2'b00);
        data_ready = 1'b0;
        cyc("ld_e", O_IDLE, 2'b00);
        for (int i = 0; i < 3; i++) cyc("ld_mwait", O_DRE, 2'b00);
        data_ready = 1'b1;
        cyc("ld_mdone", O_DRE, 2'b00);
        data_ready = 1'b0;
        cyc("ld_wb", O_WB, 2'b00);
        check_val("ld_instret", instret, 32'd2);

        // BEQ taken: retires in EXECUTE with pc_select=01
        fetch_decode("beq", OPC_BRANCH, 2'b01);
        cyc("beq_e", O_PWE, 2'b01);
        check_val("beq_instret", instret, 32'd3);
        cyc("beq_idle", O_FETCH, 2'b00);

        // FENCE: retires in EXECUTE
        fetch_decode("fence", OPC_FENCE, 2'b00);
        cyc("fence_e", O_PWE, 2'b00);
        check_val("fence_instret", instret, 32'd4);

        // JALR: retires in WRITEBACK with pc_select=10
        fetch_decode("jalr", OPC_JALR, 2'b10);
        cyc("jalr_e", O_IDLE, 2'b00);
        cyc("jalr_wb", O_WB, 2'b10);
        check_val("jalr_instret", instret, 32'd5);

        // STORE with one wait cycle, retires on data_ready
        fetch_decode("st", OPC_STORE, 2'b00);
        cyc("st_e", O_IDLE, 2'b00);
        cyc("st_mwait", O_DWE, 2'b00);
        data_ready = 1'b1;
        cyc("st_mdone", O_STEND, 2'b00);
        data_ready = 1'b0;
        check_val("st_instret", instret, 32'd6);

        // Reset asserted in MEMORY of a STORE: strobe drops without a clock edge
        fetch_decode("st2", OPC_STORE, 2'b00);
        cyc("st2_e", O_IDLE, 2'b00);
        #1;
        check_val("st2_m_en", outs(), {24'd0, O_DWE});
        reset = 1'b1;
        #1;
        check_val("st2_rst_en", outs(), {24'd0, O_FETCH});
        check_val("st2_rst_instret", instret, 32'd0);
        inst_ready = 1'b1;
        data_ready = 1'b1;
        @(posedge clock); #1;
        check_val("st2_rst_noadv_en", outs(), {24'd0, O_FETCH});
        inst_ready = 1'b0;
        data_ready = 1'b0;
        reset      = 1'b0;
        cyc("st2_post_idle", O_FETCH, 2'b00);

        // instret wrap: preload all-ones while idle in FETCH, then retire a JAL
        force dut.instret = 32'hFFFF_FFFF;
        @(posedge clock); #1;
        release dut.instret;
        fetch_decode("jal", OPC_JAL, 2'b01);
        cyc("jal_e", O_IDLE, 2'b00);
        cyc("jal_wb", O_WB, 2'b01);
        check_val("jal_wrap_instret", instret, 32'd0);

        // SYSTEM -> HALT, ready inputs ignored, reset clears
        fetch_decode("sys", OPC_SYSTEM, 2'b00);
        inst_ready = 1'b1;
        data_ready = 1'b1;
        for (int i = 0; i < 3; i++) cyc("halt", O_HLT, 2'b00);
        reset = 1'b1;
        #1;
        check_val("halt_rst_en", outs(), {24'd0, O_FETCH});
        inst_ready = 1'b0;
        data_ready = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;

        // Illegal opcode -> TRAP held for 20 cycles, reset clears
        fetch_decode("bad", OPC_BAD, 2'b01);
        for (int i = 0; i < 20; i++) begin
            inst_ready = i[0];
            data_ready = ~i[0];
            cyc("trap", O_TRP, 2'b00);
        end
        reset = 1'b1;
        #1;
        check_val("trap_rst_en", outs(), {24'd0, O_FETCH});
        inst_ready = 1'b0;
        data_ready = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        inst_opcode = OPC_OP;
        inst_ready  = 1'b1;
        cyc("post_trap_f", O_IRW, 2'b00);
        inst_ready = 1'b0;
        cyc("post_trap_d", O_IDLE, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
